axis_read_engine: RTL and testbench
===================================

Name: axis_read_engine

Overview:
- AXI4 read engine. Takes a configured start address and stream length, issues AXI read-address bursts, buffers the returned read data and serialises it into a narrow valid/ready stream.
- Sits under the stream-read configuration front end, which pulses cfg_valid once per transfer.
- Combines an address generator and a read-data buffer/width converter under a single cfg_ready.

Parameters:
- BUF_AWIDTH, 9: log2 depth of the read-data FIFO, in AXI words.
- CONFIG_DWIDTH, 32: width of cfg_address and cfg_length.
- AXI_LEN_WIDTH, 8: width of axi_arlen.
- AXI_ADDR_WIDTH, 32: width of axi_araddr, in bytes.
- AXI_DATA_WIDTH, 32: width of axi_rdata. Must be DATA_WIDTH times a power of two.
- DATA_WIDTH, 32: width of an output stream word.
- BURST_MAX, 16: maximum beats per burst. Must be ≤ 2^AXI_LEN_WIDTH and ≤ 2^BUF_AWIDTH.
- Derived:
  - RATIO = AXI_DATA_WIDTH/DATA_WIDTH
  - SHIFT = log2(RATIO)
  - BYTES = AXI_DATA_WIDTH/8

Ports:
- clk input 1: system clock; all logic on the rising edge.
- rst input 1: reset, asynchronous assert, active-low (0 = reset).
- cfg_address input CONFIG_DWIDTH: start byte address. Must be BYTES-aligned.
- cfg_length input CONFIG_DWIDTH: number of DATA_WIDTH words to stream.
- cfg_valid input 1: configuration strobe.
- cfg_ready output 1: engine idle, able to accept a configuration.
- axi_arready input 1: AR handshake.
- axi_araddr output AXI_ADDR_WIDTH: burst address.
- axi_arlen output AXI_LEN_WIDTH: beats-1.
- axi_arvalid output 1: AR valid.
- axi_rdata input AXI_DATA_WIDTH: read data.
- axi_rvalid input 1: read beat valid.
- axi_rready output 1: read beat accept.
- data output DATA_WIDTH: stream word.
- valid output 1: stream valid.
- ready input 1: stream ready.

Behaviour:
- **Reset values:**
  - cfg_ready=1, axi_arvalid=0, axi_araddr=0, axi_arlen=0, axi_rready=0, valid=0, data=0.
  - FIFO is emptied and all counters cleared.
  - Reset mid-transfer aborts it; any in-flight R beats after reset are ignored.
- **Config accept:**
  - A configuration is accepted on a cycle with cfg_valid & cfg_ready.
  - cfg_ready drops the next cycle and stays low until both:
    - all bursts have been issued, and
    - exactly cfg_length words have left the stream port.
  - cfg_valid while cfg_ready=0 is ignored.
- **Beat count:** total AXI beats = ceil(cfg_length / RATIO) = (cfg_length + RATIO-1) >> SHIFT.
- **Zero length:** cfg_length=0 issues no bursts and no output; cfg_ready returns high 1 cycle after accept.
- **Address FSM states:** IDLE, CALC, REQ.
  - **CALC:** burst beats = min(remaining beats, BURST_MAX, beats to next 4 KB boundary). The burst is issued only when free FIFO space ≥ outstanding beats + burst beats (credit scheme, so the FIFO can never overflow).
  - **REQ:**
    - axi_arvalid=1, axi_araddr = current address, axi_arlen = beats-1.
    - All three outputs hold stable until axi_arready.
    - On handshake: address += beats*BYTES, remaining -= beats, outstanding += beats.
    - Then return to CALC if remaining>0, else IDLE.
  - First axi_arvalid no earlier than 2 cycles after accept.
- **Read data:**
  - axi_rready = 1 while a transfer is active and the FIFO is not full.
  - A beat is written on axi_rvalid & axi_rready, and outstanding is decremented by 1.
  - A simultaneous AR handshake and R beat update outstanding by +beats-1.
- **Width conversion:**
  - Each FIFO word is emitted as RATIO stream words, least-significant DATA_WIDTH slice first.
  - After cfg_length words, the remaining slices of the final AXI word are discarded.
- **Stream handshake:**
  - A word transfers on valid & ready.
  - While valid=1 and ready=0, data holds stable.
  - Throughput is 1 word/cycle when the FIFO is non-empty and ready=1.
- **FIFO:**
  - Depth 2^BUF_AWIDTH, first-word fall-through permitted.
  - Simultaneous read and write when full or empty are handled without loss.

Test Plan:
- RATIO=1, cfg_address=0x1000, cfg_length=4, ready=1, slave returns 0xA0..0xA3 → one burst araddr=0x1000, arlen=3; data A0,A1,A2,A3 with valid each cycle; cfg_ready returns high after the 4th word.
- cfg_length=40, BURST_MAX=16 → bursts at 0x0 len 15, 0x40 len 15, 0x80 len 7; 40 words out in order.
- cfg_address=0x0FF8, cfg_length=8 → bursts 0x0FF8 len 1 and 0x1000 len 5 (no 4 KB crossing).
- AXI_DATA_WIDTH=64, DATA_WIDTH=32, cfg_length=3, rdata 0x11112222_33334444 then 0x55556666_77778888 → output 0x33334444, 0x11112222, 0x77778888; the last slice is dropped.
- ready held low for 200 cycles with BUF_AWIDTH=4 → no more than 16 beats outstanding plus buffered; no data loss; axi_arvalid withheld until space frees.
- cfg_length=0 → no axi_arvalid, no valid, cfg_ready high again after 1 cycle. Asserting rst mid-transfer → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/axis_read_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// axis_read_engine
//
// AXI4 read engine. Accepts a start byte address and a length in DATA_WIDTH
// words, issues AXI read bursts and serialises the returned AXI words into a
// narrow valid/ready stream. The least significant slice of each AXI word is
// sent first.
//
// Bursts are limited by the remaining beat count, BURST_MAX and the next 4 KB
// boundary. A burst is only requested when the read-data buffer can absorb
// every beat already in flight plus the new burst, so the buffer never
// overflows.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   cfg_address       start byte address (AXI-word aligned)
//   cfg_length        number of DATA_WIDTH words to stream
//   cfg_valid/ready   configuration handshake; cfg_ready=1 means idle
//   axi_ar*           AXI read-address channel (master side)
//   axi_r*            AXI read-data channel (master side)
//   data/valid/ready  output stream
// ---------------------------------------------------------------------------
module axis_read_engine #(
    parameter int BUF_AWIDTH     = 9,
    parameter int CONFIG_DWIDTH  = 32,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BURST_MAX      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CONFIG_DWIDTH-1:0]  cfg_address,
    input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
    output logic                      axi_arvalid,
    input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    output logic [DATA_WIDTH-1:0]     data,
    output logic                      valid,
    input  logic                      ready
);

    localparam int RATIO      = AXI_DATA_WIDTH / DATA_WIDTH;
    localparam int SHIFT      = $clog2(RATIO);
    localparam int BYTES      = AXI_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int DEPTH      = 1 << BUF_AWIDTH;
    localparam int PW         = BUF_AWIDTH + 1;          // pointer / occupancy width
    localparam int CW         = BUF_AWIDTH + 2;          // credit arithmetic width
    localparam int BW         = $clog2(BURST_MAX + 1);   // burst beat count width
    localparam int SW         = (SHIFT > 0) ? SHIFT : 1; // slice index width

    typedef enum logic [1:0] {IDLE, CALC, REQ} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic                      active;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr;
    logic [AXI_LEN_WIDTH-1:0]  arlen_r;
    logic [BW-1:0]             burst_len;
    logic [BW-1:0]             burst_beats;
    logic [CONFIG_DWIDTH-1:0]  beats_left;
    logic [CONFIG_DWIDTH-1:0]  words_left;
    logic [CONFIG_DWIDTH-1:0]  beats_init;
    logic [CONFIG_DWIDTH:0]    len_round;
    logic [CONFIG_DWIDTH-1:0]  lim;
    logic [12:0]               bytes_to_4k;
    logic [12:0]               beats_to_4k;
    logic [PW-1:0]             outstanding;
    logic [CW-1:0]             used;
    logic [CW-1:0]             free_space;
    logic [CW-1:0]             need;
    logic                      credit_ok;
    logic                      cfg_fire;
    logic                      ar_fire;
    logic                      r_fire;
    logic                      out_fire;
    logic                      xfer_done;

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [PW-1:0]             fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      pop;

    logic [AXI_DATA_WIDTH-1:0] word_p1;
    logic                      vld_p1;
    logic [SW-1:0]             slice_p1;
    logic                      last_slice;
    logic                      word_done;

    assign cfg_ready  = ~active;
    assign cfg_fire   = cfg_valid & cfg_ready;
    assign ar_fire    = axi_arvalid & axi_arready;
    assign r_fire     = axi_rvalid & axi_rready;
    assign out_fire   = vld_p1 & ready;
    assign axi_araddr = cur_addr;
    assign axi_arlen  = arlen_r;
    assign axi_rready = active & ~fifo_full;
    assign valid      = vld_p1;

    // A transfer ends once no more bursts are pending and every word has left.
    assign xfer_done  = active & (state == IDLE) & (words_left == '0);

    // Total AXI beats = ceil(cfg_length / RATIO).
    assign len_round  = {1'b0, cfg_length} + (CONFIG_DWIDTH + 1)'(RATIO - 1);
    assign beats_init = CONFIG_DWIDTH'(len_round >> SHIFT);

    // Address is AXI-word aligned, so the byte distance divides exactly.
    assign bytes_to_4k = 13'd4096 - {1'b0, cur_addr[11:0]};
    assign beats_to_4k = bytes_to_4k >> BYTE_SHIFT;

    always_comb begin
        lim = CONFIG_DWIDTH'(BURST_MAX);
        if (beats_left < lim) begin
            lim = beats_left;
        end
        if (CONFIG_DWIDTH'(beats_to_4k) < lim) begin
            lim = CONFIG_DWIDTH'(beats_to_4k);
        end
        burst_beats = BW'(lim);
    end

    // Buffer space is counted including the word held in the output register,
    // so beats in flight plus stored words never exceed DEPTH.
    assign used       = CW'(fifo_count) + CW'(vld_p1);
    assign free_space = CW'(DEPTH) - used;
    assign need       = CW'(outstanding) + CW'(burst_beats);
    assign credit_ok  = free_space >= need;

    // ---- address generator -------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        axi_arvalid = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_fire && (beats_init != '0)) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (credit_ok) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    state_nxt = (beats_left == CONFIG_DWIDTH'(burst_len)) ? IDLE : CALC;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active      <= 1'b0;
            cur_addr    <= '0;
            arlen_r     <= '0;
            burst_len   <= '0;
            beats_left  <= '0;
            words_left  <= '0;
            outstanding <= '0;
        end else begin
            if (cfg_fire) begin
                active     <= 1'b1;
                cur_addr   <= AXI_ADDR_WIDTH'(cfg_address);
                beats_left <= beats_init;
                words_left <= cfg_length;
            end else if (xfer_done) begin
                active <= 1'b0;
            end
            if ((state == CALC) && credit_ok) begin
                burst_len <= burst_beats;
                arlen_r   <= AXI_LEN_WIDTH'(burst_beats - BW'(1));
            end
            if (ar_fire) begin
                cur_addr   <= cur_addr + (AXI_ADDR_WIDTH'(burst_len) << BYTE_SHIFT);
                beats_left <= beats_left - CONFIG_DWIDTH'(burst_len);
            end
            outstanding <= outstanding + (ar_fire ? PW'(burst_len) : PW'(0))
                                       - (r_fire ? PW'(1) : PW'(0));
            if (out_fire) begin
                words_left <= words_left - CONFIG_DWIDTH'(1);
            end
        end
    end

    // ---- read-data buffer --------------------------------------------------
    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == PW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);

    always_ff @(posedge clk) begin
        if (r_fire) begin
            mem[wr_ptr[BUF_AWIDTH-1:0]] <= axi_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (r_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // ---- p1: width conversion / stream output ------------------------------
    // The final word of a transfer may end mid AXI word; its upper slices are
    // dropped by retiring the word early.
    assign last_slice = (slice_p1 == SW'(RATIO - 1));
    assign word_done  = out_fire & (last_slice | (words_left == CONFIG_DWIDTH'(1)));
    assign pop        = ~fifo_empty & (~vld_p1 | word_done);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            word_p1  <= '0;
            slice_p1 <= '0;
        end else begin
            if (pop) begin
                vld_p1   <= 1'b1;
                word_p1  <= mem[rd_ptr[BUF_AWIDTH-1:0]];
                slice_p1 <= '0;
            end else if (word_done) begin
                vld_p1 <= 1'b0;
            end else if (out_fire) begin
                slice_p1 <= slice_p1 + SW'(1);
            end
        end
    end

    always_comb begin
        data = word_p1[DATA_WIDTH-1:0];
        for (int i = 1; i < RATIO; i++) begin
            if (slice_p1 == SW'(i)) begin
                data = word_p1[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_axis_read_engine.sv
`timescale 1ns/1ps
// Bench for axis_read_engine: one instance with 32-bit AXI data and a 16-word
// buffer, one instance with 64-bit AXI data feeding a 32-bit stream.
module tb_axis_read_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // instance A: RATIO=1, depth 16
    logic [31:0] a_cfg_address, a_cfg_length;
    logic        a_cfg_valid, a_cfg_ready;
    logic        a_arready, a_arvalid, a_rvalid, a_rready, a_valid, a_ready;
    logic [31:0] a_araddr, a_rdata, a_data;
    logic [7:0]  a_arlen;
    // instance B: 64-bit AXI, 32-bit stream
    logic [31:0] b_cfg_address, b_cfg_length;
    logic        b_cfg_valid, b_cfg_ready;
    logic        b_arready, b_arvalid, b_rvalid, b_rready, b_valid, b_ready;
    logic [31:0] b_araddr, b_data;
    logic [63:0] b_rdata;
    logic [7:0]  b_arlen;

    axis_read_engine #(.BUF_AWIDTH(4)) dut_a (
        .clk(clk), .rst(rst),
        .cfg_address(a_cfg_address), .cfg_length(a_cfg_length),
        .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
        .axi_arready(a_arready), .axi_araddr(a_araddr), .axi_arlen(a_arlen),
        .axi_arvalid(a_arvalid), .axi_rdata(a_rdata), .axi_rvalid(a_rvalid),
        .axi_rready(a_rready), .data(a_data), .valid(a_valid), .ready(a_ready)
    );

    axis_read_engine #(.AXI_DATA_WIDTH(64), .DATA_WIDTH(32)) dut_b (
        .clk(clk), .rst(rst),
        .cfg_address(b_cfg_address), .cfg_length(b_cfg_length),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
        .axi_arready(b_arready), .axi_araddr(b_araddr), .axi_arlen(b_arlen),
        .axi_arvalid(b_arvalid), .axi_rdata(b_rdata), .axi_rvalid(b_rvalid),
        .axi_rready(b_rready), .data(b_data), .valid(b_valid), .ready(b_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    typedef struct {
        logic [31:0]      addr;
        logic [31:0]      len;
        int               nb;
        logic [0:2][31:0] baddr;
        logic [0:2][7:0]  blen;
        bit               contig;
    } vec_t;

    burst_t      a_bursts[$], b_bursts[$];
    logic [31:0] a_beatq[$], b_beatq[$];
    logic [31:0] a_rx[$], b_rx[$];
    int          a_rx_t[$];
    int          a_issued = 0;
    bit          a_ready_en = 1'b1;
    bit          a_credit_chk = 1'b0;
    logic [63:0] bmem[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // slave A data: word at 0x1000 is 0xA0, next word 0xA1, ...
    function automatic logic [31:0] fa(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h1000) >> 2);
    endfunction

    // Slave A: every AR is stalled two cycles; R beats returned back to back.
    initial begin
        int          wait_n;
        bit          hold_pend;
        logic [31:0] hold_addr;
        logic [7:0]  hold_len;
        wait_n = 0; hold_pend = 0; hold_addr = '0; hold_len = '0;
        a_arready = 0; a_rvalid = 0; a_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                a_beatq.delete();
                a_arready = 0; a_rvalid = 0; wait_n = 0; hold_pend = 0;
                continue;
            end
            if (hold_pend) begin
                check("ar_hold", {a_arvalid, a_araddr, a_arlen}, {1'b1, hold_addr, hold_len});
            end
            a_arready = a_arvalid && (wait_n >= 2);
            if (a_arvalid && !a_arready) wait_n++;
            hold_pend = a_arvalid && !a_arready;
            hold_addr = a_araddr;
            hold_len  = a_arlen;
            if (a_beatq.size() > 0) begin
                a_rvalid = 1; a_rdata = fa(a_beatq[0]);
            end else begin
                a_rvalid = 0; a_rdata = '0;
            end
            // handshakes taking place at the coming rising edge
            if (a_arvalid && a_arready) begin
                wait_n = 0;
                a_bursts.push_back('{a_araddr, a_arlen});
                a_issued += int'(a_arlen) + 1;
                for (int i = 0; i <= int'(a_arlen); i++) a_beatq.push_back(a_araddr + 32'(4 * i));
            end
            if (a_rvalid && a_rready) void'(a_beatq.pop_front());
            if (a_credit_chk) begin
                check("credit", 64'((a_issued - a_rx.size()) <= 16), 64'd1);
            end
        end
    end

    // Monitor A: drives ready, records words and their cycle, checks stall hold.
    initial begin
        bit          stall_pend;
        logic [31:0] stall_data;
        stall_pend = 0; stall_data = '0;
        a_ready = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (stall_pend && rst) check("stall_hold", {a_valid, a_data}, {1'b1, stall_data});
            a_ready = a_ready_en;
            stall_pend = rst && a_valid && !a_ready;
            stall_data = a_data;
            if (rst && a_valid && a_ready) begin
                a_rx.push_back(a_data);
                a_rx_t.push_back(cyc);
            end
        end
    end

    // Slave B: AR accepted at once, R data looked up by address bits [5:3].
    initial begin
        logic [31:0] t;
        for (int k = 0; k < 8; k++) bmem[k] = {32'hB000_0001 + 32'(2 * k), 32'hB000_0000 + 32'(2 * k)};
        bmem[0] = 64'h1111_2222_3333_4444;
        bmem[1] = 64'h5555_6666_7777_8888;
        b_arready = 0; b_rvalid = 0; b_rdata = '0; b_ready = 0;
        forever begin
            @(negedge clk);
            b_ready = 1;
            if (!rst) begin
                b_beatq.delete(); b_arready = 0; b_rvalid = 0;
                continue;
            end
            b_arready = b_arvalid;
            if (b_beatq.size() > 0) begin
                t = b_beatq[0];
                b_rvalid = 1; b_rdata = bmem[t[5:3]];
            end else begin
                b_rvalid = 0; b_rdata = '0;
            end
            if (b_arvalid && b_arready) begin
                b_bursts.push_back('{b_araddr, b_arlen});
                for (int i = 0; i <= int'(b_arlen); i++) b_beatq.push_back(b_araddr + 32'(8 * i));
            end
            if (b_rvalid && b_rready) void'(b_beatq.pop_front());
            if (b_valid && b_ready) b_rx.push_back(b_data);
        end
    end

    task automatic cfg(input bit sel, input logic [31:0] addr, input logic [31:0] len);
        @(negedge clk);
        if (sel) begin b_cfg_address = addr; b_cfg_length = len; b_cfg_valid = 1; end
        else     begin a_cfg_address = addr; a_cfg_length = len; a_cfg_valid = 1; end
        @(negedge clk);
        a_cfg_valid = 0; b_cfg_valid = 0;
    endtask

    task automatic wait_idle(input bit sel, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            if ((sel ? b_cfg_ready : a_cfg_ready) === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic cmp_words(input string nm, input logic [31:0] got[$], input logic [31:0] exp[$]);
        check({nm, "_count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) check({nm, "_word"}, got[i], exp[i]);
    endtask

    task automatic check_reset(input string nm);
        check({nm, "_a_ctl"}, {a_cfg_ready, a_arvalid, a_rready, a_valid, a_arlen}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h0});
        check({nm, "_a_addr"}, a_araddr, 0);
        check({nm, "_a_data"}, a_data, 0);
        check({nm, "_b_ctl"}, {b_cfg_ready, b_arvalid, b_rready, b_valid, b_arlen}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h0});
        check({nm, "_b_addr"}, b_araddr, 0);
        check({nm, "_b_data"}, b_data, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        logic [31:0] exp[$];
        bit          ok;

        vecs[0] = '{32'h1000, 32'd4,  1, '{32'h1000, 32'h0,    32'h0}, '{8'd3,  8'd0,  8'd0}, 1'b1};
        vecs[1] = '{32'h0000, 32'd40, 3, '{32'h0,    32'h40,   32'h80}, '{8'd15, 8'd15, 8'd7}, 1'b0};
        vecs[2] = '{32'h0FF8, 32'd8,  2, '{32'h0FF8, 32'h1000, 32'h0}, '{8'd1,  8'd5,  8'd0}, 1'b0};
        vecs[3] = '{32'h2FF0, 32'd20, 2, '{32'h2FF0, 32'h3000, 32'h0}, '{8'd3,  8'd15, 8'd0}, 1'b0};
        vecs[4] = '{32'h0500, 32'd1,  1, '{32'h0500, 32'h0,    32'h0}, '{8'd0,  8'd0,  8'd0}, 1'b0};

        rst = 0;
        a_cfg_address = '0; a_cfg_length = '0; a_cfg_valid = 0;
        b_cfg_address = '0; b_cfg_length = '0; b_cfg_valid = 0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1;
        repeat (2) @(negedge clk);

        // table-driven transfers on instance A
        for (int v = 0; v < 5; v++) begin
            a_bursts.delete(); a_rx.delete(); a_rx_t.delete();
            cfg(0, vecs[v].addr, vecs[v].len);
            check("cfg_ready_drop", a_cfg_ready, 0);
            check("ar_latency", a_arvalid, 0);
            wait_idle(0, 2000, ok);
            check("done", ok, 1);
            check("nbursts", a_bursts.size(), vecs[v].nb);
            for (int b = 0; b < vecs[v].nb && b < a_bursts.size(); b++) begin
                check("araddr", a_bursts[b].addr, vecs[v].baddr[b]);
                check("arlen", a_bursts[b].len, vecs[v].blen[b]);
            end
            exp.delete();
            for (int i = 0; i < int'(vecs[v].len); i++) exp.push_back(fa(vecs[v].addr + 32'(4 * i)));
            cmp_words("a_stream", a_rx, exp);
            if (vecs[v].contig) begin
                for (int i = 1; i < a_rx_t.size(); i++) check("back_to_back", a_rx_t[i], a_rx_t[i-1] + 1);
            end
        end

        // zero length: cfg_ready low for exactly one cycle, no traffic
        a_bursts.delete(); a_rx.delete();
        cfg(0, 32'h0000_2000, 32'd0);
        check("zero_busy", {a_cfg_ready, a_arvalid, a_valid}, 3'b000);
        @(negedge clk);
        check("zero_idle", {a_cfg_ready, a_arvalid, a_valid}, 3'b100);
        repeat (5) @(negedge clk);
        check("zero_nburst", a_bursts.size(), 0);
        check("zero_nword", a_rx.size(), 0);

        // consumer stalled for 200 cycles: only one burst fits the 16-word buffer
        a_bursts.delete(); a_rx.delete(); a_issued = 0;
        a_ready_en = 0; a_credit_chk = 1;
        cfg(0, 32'h0, 32'd40);
        repeat (200) @(negedge clk);
        check("stall_issued", a_issued, 16);
        check("stall_arvalid", a_arvalid, 0);
        a_ready_en = 1;
        wait_idle(0, 3000, ok);
        check("stall_done", ok, 1);
        a_credit_chk = 0;
        exp.delete();
        for (int i = 0; i < 40; i++) exp.push_back(fa(32'(4 * i)));
        cmp_words("stall_stream", a_rx, exp);

        // width conversion on instance B
        b_bursts.delete(); b_rx.delete();
        cfg(1, 32'h0, 32'd3);
        wait_idle(1, 500, ok);
        check("b3_done", ok, 1);
        check("b3_nburst", b_bursts.size(), 1);
        if (b_bursts.size() > 0) begin
            check("b3_araddr", b_bursts[0].addr, 0);
            check("b3_arlen", b_bursts[0].len, 1);
        end
        exp = '{32'h3333_4444, 32'h1111_2222, 32'h7777_8888};
        repeat (3) @(negedge clk);
        cmp_words("b3_stream", b_rx, exp);

        b_bursts.delete(); b_rx.delete();
        cfg(1, 32'h0, 32'd4);
        wait_idle(1, 500, ok);
        check("b4_done", ok, 1);
        exp = '{32'h3333_4444, 32'h1111_2222, 32'h7777_8888, 32'h5555_6666};
        cmp_words("b4_stream", b_rx, exp);

        b_bursts.delete(); b_rx.delete();
        cfg(1, 32'h10, 32'd5);
        wait_idle(1, 500, ok);
        check("b5_done", ok, 1);
        check("b5_nburst", b_bursts.size(), 1);
        if (b_bursts.size() > 0) check("b5_arlen", b_bursts[0].len, 2);
        exp = '{32'hB000_0004, 32'hB000_0005, 32'hB000_0006, 32'hB000_0007, 32'hB000_0008};
        cmp_words("b5_stream", b_rx, exp);

        // reset in the middle of a transfer, then recover
        a_rx.delete();
        cfg(0, 32'h0, 32'd40);
        for (int i = 0; i < 300 && a_rx.size() < 3; i++) @(negedge clk);
        check("rst_mid_started", 64'(a_rx.size() >= 3), 64'd1);
        rst = 0;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        a_bursts.delete(); a_rx.delete();
        cfg(0, 32'h1000, 32'd4);
        wait_idle(0, 500, ok);
        check("recover_done", ok, 1);
        exp = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        cmp_words("recover_stream", a_rx, exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
